// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the small arithmetic blocks:
//   - state encoding of the iterative divider FSM (IDLE/RUN/FIN)
//   - default operand width
//   - count_width(): bits needed to hold a step count of 0..w,
//     i.e. clog2(w+1)
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_e;

    // Number of bits required to represent the value w (clog2(w+1)).
    function automatic int count_width(input int w);
        int bits;
        int val;
        bits = 0;
        val  = w;
        while (val > 0) begin
            bits = bits + 1;
            val  = val >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end else begin
            bits = bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/add_sub_nbit.sv
// ---------------------------------------------------------------------------
// add_sub_nbit
// Parameterised ripple-carry adder/subtractor.
//   op_i = 0 : sum_o = a_i + b_i
//   op_i = 1 : sum_o = a_i - b_i  (B inverted, carry-in 1)
// Ports:
//   a_i    [N-1:0]  operand A
//   b_i    [N-1:0]  operand B
//   op_i            0 = add, 1 = subtract (also the carry-in)
//   sum_o  [N-1:0]  result
//   cout_o          carry out; in subtract mode 1 means "no borrow" (A >= B)
// Purely combinational.
// ---------------------------------------------------------------------------
module add_sub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         op_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic         carry_s;
    logic         b_x_s;
    logic [N-1:0] sum_s;

    // Ripple carry chain; B is conditionally inverted by op, op is carry-in.
    always_comb begin
        carry_s = op_i;
        b_x_s   = 1'b0;
        sum_s   = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            b_x_s    = b_i[i] ^ op_i;
            sum_s[i] = a_i[i] ^ b_x_s ^ carry_s;
            carry_s  = (a_i[i] & b_x_s) | (a_i[i] & carry_s) | (b_x_s & carry_s);
        end
        sum_o  = sum_s;
        cout_o = carry_s;
    end

endmodule

// File: rtl/restoring_div4.sv
// ---------------------------------------------------------------------------
// restoring_div4
// Iterative unsigned restoring divider with start/done handshake.
// One quotient bit is produced per cycle by trial subtraction on a
// WIDTH+1 bit subtractor (add_sub_nbit fixed in subtract mode).
// Ports:
//   clk_i                      rising-edge clock
//   rst_i                      synchronous active-high reset
//   start_i                    request, only honoured in IDLE
//   dividend_i    [WIDTH-1:0]  dividend, latched on accepted start
//   divisor_i     [WIDTH-1:0]  divisor, latched on accepted start
//   busy_o                     high while iterating (RUN)
//   done_o                     one-cycle pulse when results are valid
//   quotient_o    [WIDTH-1:0]  quotient, held until the next result
//   remainder_o   [WIDTH-1:0]  remainder, held until the next result
//   div_by_zero_o              set with done when the divisor was 0
// All outputs are registered.
// ---------------------------------------------------------------------------
module restoring_div4
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int             CW       = count_width(WIDTH);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;          // partial remainder
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // latched divisor
    logic [CW-1:0]    cnt_q, cnt_d;      // remaining steps
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift_s;
    logic [WIDTH-1:0] q_shift_s;
    logic [WIDTH:0]   trial_s;
    logic             no_borrow_s;
    logic [WIDTH:0]   r_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             unused_s;

    // Left shift of {R,Q}: the MSB of Q moves into the LSB of R. R is always
    // below the divisor between steps, so its top bit is 0 before the shift.
    assign r_shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_shift_s = {q_q[WIDTH-2:0], 1'b0};
    assign unused_s  = r_q[WIDTH];

    add_sub_nbit #(
        .N (WIDTH + 1)
    ) u_sub (
        .a_i    (r_shift_s),
        .b_i    ({1'b0, d_q}),
        .op_i   (1'b1),
        .sum_o  (trial_s),
        .cout_o (no_borrow_s)
    );

    // One restoring step: keep the trial difference only when there was no borrow.
    always_comb begin
        if (no_borrow_s) begin
            r_next_s = trial_s;
            q_next_s = q_shift_s | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_next_s = r_shift_s;
            q_next_s = q_shift_s;
        end
    end

    // Next-state and datapath control; every register holds unless changed.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i != {WIDTH{1'b0}}) begin
                        d_d     = divisor_i;
                        q_d     = dividend_i;
                        r_d     = {(WIDTH+1){1'b0}};
                        cnt_d   = CNT_INIT;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        // Divide by zero skips the iteration entirely.
                        quo_d   = {WIDTH{1'b1}};
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = r_next_s;
                q_d   = q_next_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Last step: publish results as FIN is entered.
                    quo_d   = q_next_s;
                    rem_d   = r_next_s[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            r_q     <= {(WIDTH+1){1'b0}};
            q_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_div4.sv
// ---------------------------------------------------------------------------
// tb_restoring_div4
// Scoreboard bench: stimulus pushes the expected result when it issues a
// start; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_restoring_div4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    restoring_div4 #(.WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done with q=%0d r=%0d expected no done",
                         quotient_o, remainder_o);
            end else begin
                e = sb.pop_front();
                chk($sformatf("quotient %0d/%0d", e.a, e.b), int'(quotient_o), e.q);
                chk($sformatf("remainder %0d/%0d", e.a, e.b), int'(remainder_o), e.r);
                chk($sformatf("div_by_zero %0d/%0d", e.a, e.b), int'(div_by_zero_o), e.z);
                if (e.z == 0) begin
                    chk($sformatf("invariant %0d/%0d", e.a, e.b),
                        int'(quotient_o) * e.b + int'(remainder_o), e.a);
                    chk($sformatf("rem_lt_div %0d/%0d", e.a, e.b),
                        int'(remainder_o) < e.b ? 1 : 0, 1);
                end
            end
        end
    end

    // Issue one division, then wait (bounded) for done and check latency/busy.
    task automatic do_div(input int a, input int b, input int eq, input int er, input int ez);
        exp_t e;
        int   got;
        e.a = a; e.b = b; e.q = eq; e.r = er; e.z = ez;
        sb.push_back(e);
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom_range(15));
        divisor  = W'($urandom_range(15));
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                got = k;
                break;
            end
            if (ez == 0) chk($sformatf("busy %0d/%0d c%0d", a, b, k), int'(busy_o), 1);
        end
        chk($sformatf("latency %0d/%0d", a, b), got, (ez != 0) ? 1 : W + 1);
        chk($sformatf("busy_at_done %0d/%0d", a, b), int'(busy_o), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, int'(busy_o), 0);
        chk({tag, " done"}, int'(done_o), 0);
        chk({tag, " quotient"}, int'(quotient_o), 0);
        chk({tag, " remainder"}, int'(remainder_o), 0);
        chk({tag, " div_by_zero"}, int'(div_by_zero_o), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int eq;
        int er;
        int ez;
        rst      = 1'b1;
        start    = 1'b1;          // start together with reset must be ignored
        dividend = 4'd13;
        divisor  = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Basic case, with held-output check afterwards.
        do_div(13, 3, 4, 1, 0);
        repeat (3) @(negedge clk);
        chk("held quotient", int'(quotient_o), 4);
        chk("held remainder", int'(remainder_o), 1);
        chk("held done", int'(done_o), 0);
        chk("held busy", int'(busy_o), 0);

        // Boundary values.
        do_div(15, 1, 15, 0, 0);
        do_div(7, 9, 0, 7, 0);
        do_div(15, 15, 1, 0, 0);

        // Divide by zero, then a normal division clears the flag.
        do_div(9, 0, 15, 9, 1);
        do_div(6, 4, 1, 2, 0);

        // Start while busy is ignored and not queued.
        sb.push_back('{13, 3, 4, 1, 0});
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;                // edge 0: accepted
        start = 1'b0;
        @(posedge clk); #1;                // cycle 2
        start = 1'b1; dividend = 4'd8; divisor = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(negedge clk);        // monitor flags any second done
        chk("ignored_start quotient", int'(quotient_o), 4);
        chk("ignored_start remainder", int'(remainder_o), 1);
        chk("ignored_start sb_empty", sb.size(), 0);

        // Reset during an operation aborts it without done.
        @(posedge clk); #1;
        start = 1'b1; dividend = 4'd14; divisor = 4'd5;
        @(posedge clk); #1;                // edge 0
        start = 1'b0;
        @(posedge clk); #1;                // cycle 2
        @(posedge clk); #1;                // cycle 3
        rst = 1'b1;
        @(negedge clk);
        chk("pre_abort busy", int'(busy_o), 1);
        @(negedge clk);                    // cycle 4
        chk_all_zero("abort");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_div(14, 5, 2, 4, 0);

        // Exhaustive sweep, back to back.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 15; er = a; ez = 1;
                end else begin
                    eq = a / b; er = a % b; ez = 0;
                end
                do_div(a, b, eq, er, ez);
            end
        end

        repeat (10) @(negedge clk);
        chk("final sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
